// File: rtl/mulpreadd_pkg.sv
// Shared width/latency helpers and operand extension for mulpreadd_pipe.
// Used by mulpreadd_stage and mulpreadd_pipe.
package mulpreadd_pkg;

   localparam int EXT_W = 64;

   function automatic int max2(int x, int y);
      return (x > y) ? x : y;
   endfunction

   function automatic int pw_f(int wb, int wc);
      return max2(wb, wc) + 2;
   endfunction

   function automatic int zw_f(int wa, int wb, int wc);
      return wa + pw_f(wb, wc) + 1;
   endfunction

   function automatic int dep_f(int ra, int rb, int rc);
      return max2(max2(ra, rb), rc);
   endfunction

   function automatic int lat_f(int ra, int rb, int rc,
                                int rp, int rz);
      return dep_f(ra, rb, rc) + rp + rz;
   endfunction

   // widen a w-bit operand, sign- or zero-extending by flag s
   function automatic logic [EXT_W-1:0] ext_op(
      logic [EXT_W-1:0] v, int w, logic s);
      logic [EXT_W-1:0] hi;
      hi = {EXT_W{1'b1}} << w;
      return (s && v[6'(w - 1)]) ? (v | hi) : (v & ~hi);
   endfunction

endpackage

// File: rtl/mulpreadd_stage.sv
// One optional pipeline register: clear/load qualified by strobe,
// or a plain wire when EN = 0.
module mulpreadd_stage
   import mulpreadd_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int EN    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             strobe,
   input  logic             ce,
   input  logic             rst_x,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (EN != 0) begin : g_reg
      // global reset, then strobed clear, then strobed load
      always_ff @(posedge clk) begin
         if (rst)
            q <= '0;
         else if (strobe && rst_x)
            q <= '0;
         else if (strobe && ce)
            q <= d;
      end
   end else begin : g_byp
      logic unused_ctl;
      assign q = d;
      assign unused_ctl = &{1'b0, clk, rst, strobe, ce, rst_x};
   end

endmodule

// File: rtl/mulpreadd_pipe.sv
// Pre-add multiplier z = a * (b + c) with per-stage optional registers.
// Macro MULTPREADD_ALIGN_EN pads shallow operand paths to equal depth.
module mulpreadd_pipe
   import mulpreadd_pkg::*;
#(
   parameter int WA    = 18,
   parameter int WB    = 18,
   parameter int WC    = 18,
   parameter int REG_A = 0,
   parameter int REG_B = 0,
   parameter int REG_C = 1,
   parameter int REG_P = 0,
   parameter int REG_Z = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         strobe,
   input  logic                         a_signed,
   input  logic                         b_signed,
   input  logic                         c_signed,
   input  logic [WA-1:0]                a,
   input  logic [WB-1:0]                b,
   input  logic [WC-1:0]                c,
   input  logic                         ce_a,
   input  logic                         ce_b,
   input  logic                         ce_c,
   input  logic                         rst_a,
   input  logic                         rst_b,
   input  logic                         rst_c,
   input  logic                         in_valid,
   output logic                         out_valid,
   output logic [zw_f(WA,WB,WC)-1:0]    z
);

   localparam int PW  = pw_f(WB, WC);
   localparam int ZW  = zw_f(WA, WB, WC);
   localparam int DEP = dep_f(REG_A, REG_B, REG_C);
   localparam int LAT = lat_f(REG_A, REG_B, REG_C, REG_P, REG_Z);

`ifdef MULTPREADD_ALIGN_EN
   localparam int PAD_A = DEP - REG_A;
   localparam int PAD_B = DEP - REG_B;
   localparam int PAD_C = DEP - REG_C;
`else
   localparam int PAD_A = 0;
   localparam int PAD_B = 0;
   localparam int PAD_C = 0;
`endif

   logic [WA:0] a_r, a_q;
   logic [WB:0] b_r, b_q;
   logic [WC:0] c_r, c_q;

   logic signed [WA:0]   a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] c_ext;
   logic signed [PW-1:0] sum;
   logic [PW-1:0]        p_raw;
   logic signed [ZW-1:0] a_w;
   logic signed [ZW-1:0] p_w;
   logic signed [ZW-1:0] prod;

   // operand registers; the signed flag rides in the top bit
   mulpreadd_stage #(.WIDTH(WA+1), .EN(REG_A)) u_reg_a (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce(ce_a), .rst_x(rst_a),
      .d({a_signed, a}), .q(a_r));

   mulpreadd_stage #(.WIDTH(WB+1), .EN(REG_B)) u_reg_b (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce(ce_b), .rst_x(rst_b),
      .d({b_signed, b}), .q(b_r));

   mulpreadd_stage #(.WIDTH(WC+1), .EN(REG_C)) u_reg_c (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce(ce_c), .rst_x(rst_c),
      .d({c_signed, c}), .q(c_r));

   // padding registers, wires unless alignment adds depth
   mulpreadd_stage #(.WIDTH(WA+1), .EN(PAD_A)) u_pad_a (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce(ce_a), .rst_x(rst_a),
      .d(a_r), .q(a_q));

   mulpreadd_stage #(.WIDTH(WB+1), .EN(PAD_B)) u_pad_b (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce(ce_b), .rst_x(rst_b),
      .d(b_r), .q(b_q));

   mulpreadd_stage #(.WIDTH(WC+1), .EN(PAD_C)) u_pad_c (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce(ce_c), .rst_x(rst_c),
      .d(c_r), .q(c_q));

   assign a_ext = (WA+1)'(ext_op(EXT_W'(a_q[WA-1:0]), WA, a_q[WA]));
   assign b_ext = PW'(ext_op(EXT_W'(b_q[WB-1:0]), WB, b_q[WB]));
   assign c_ext = PW'(ext_op(EXT_W'(c_q[WC-1:0]), WC, c_q[WC]));
   assign sum   = b_ext + c_ext;

   mulpreadd_stage #(.WIDTH(PW), .EN(REG_P)) u_reg_p (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce(1'b1), .rst_x(1'b0),
      .d(sum), .q(p_raw));

   assign a_w  = ZW'(a_ext);
   assign p_w  = ZW'($signed(p_raw));
   assign prod = a_w * p_w;

   mulpreadd_stage #(.WIDTH(ZW), .EN(REG_Z)) u_reg_z (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce(1'b1), .rst_x(1'b0),
      .d(prod), .q(z));

   if (LAT == 0) begin : g_vld_comb
      assign out_valid = in_valid;
   end else begin : g_vld_sr
      logic [LAT-1:0] vld_sr;

      // tag shift register; only rst drops in-flight tags
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_sr <= '0;
         end else if (strobe) begin
            vld_sr[0] <= in_valid;
            for (int i = 1; i < LAT; i++)
               vld_sr[i] <= vld_sr[i-1];
         end
      end

      assign out_valid = vld_sr[LAT-1];
   end

endmodule

// File: tb/tb_mulpreadd_pipe.sv
// Bench for mulpreadd_pipe: all 32 REG_* combinations side by side,
// checked every cycle against a numeric model plus literal checks.
module tb_mulpreadd_pipe;

   localparam int NC  = 32;
   localparam int ZW  = 39;
   localparam int DUT = 20;

`ifdef MULTPREADD_ALIGN_EN
   localparam bit AL = 1'b1;
`else
   localparam bit AL = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, strobe, in_valid;
   logic a_signed, b_signed, c_signed;
   logic ce_a, ce_b, ce_c, rst_a, rst_b, rst_c;
   logic [17:0] a, b, c;

   logic [ZW-1:0] zo [NC];
   logic          vo [NC];

   for (genvar g = 0; g < NC; g++) begin : g_dut
      mulpreadd_pipe #(
         .REG_A(g % 2), .REG_B((g / 2) % 2), .REG_C((g / 4) % 2),
         .REG_P((g / 8) % 2), .REG_Z((g / 16) % 2)
      ) u_dut (
         .clk(clk), .rst(rst), .strobe(strobe),
         .a_signed(a_signed), .b_signed(b_signed),
         .c_signed(c_signed),
         .a(a), .b(b), .c(c),
         .ce_a(ce_a), .ce_b(ce_b), .ce_c(ce_c),
         .rst_a(rst_a), .rst_b(rst_b), .rst_c(rst_c),
         .in_valid(in_valid), .out_valid(vo[g]), .z(zo[g]));
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(string nm, longint got, longint want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   // numeric model: operand slots hold already-extended integer values
   longint ar [NC], ap [NC], br [NC], bp [NC], cr [NC], cp [NC];
   longint pr [NC], zr [NC];
   bit [2:0] vs [NC];

   function automatic bit rg(int i, int k);
      return ((i >> k) & 1) == 1;
   endfunction

   function automatic bit deep(int i);
      return rg(i, 0) || rg(i, 1) || rg(i, 2);
   endfunction

   function automatic int lat(int i);
      return int'(deep(i)) + int'(rg(i, 3)) + int'(rg(i, 4));
   endfunction

   function automatic longint sx(logic [17:0] raw, logic s);
      longint v;
      v = longint'(raw);
      if (s && raw[17]) v = v - 262144;
      return v;
   endfunction

   function automatic longint upd(longint cur, longint d,
                                  logic ce, logic cl);
      if (rst) return 0;
      if (strobe && cl) return 0;
      if (strobe && ce) return d;
      return cur;
   endfunction

   function automatic void opnd(int i,
      output longint aa, output longint ba, output longint ca,
      output longint av, output longint bv, output longint cv);
      aa = rg(i, 0) ? ar[i] : sx(a, a_signed);
      ba = rg(i, 1) ? br[i] : sx(b, b_signed);
      ca = rg(i, 2) ? cr[i] : sx(c, c_signed);
      av = (AL && deep(i) && !rg(i, 0)) ? ap[i] : aa;
      bv = (AL && deep(i) && !rg(i, 1)) ? bp[i] : ba;
      cv = (AL && deep(i) && !rg(i, 2)) ? cp[i] : ca;
   endfunction

   function automatic longint zexp(int i);
      longint aa, ba, ca, av, bv, cv, pv;
      opnd(i, aa, ba, ca, av, bv, cv);
      pv = rg(i, 3) ? pr[i] : bv + cv;
      return rg(i, 4) ? zr[i] : av * pv;
   endfunction

   function automatic bit vexp(int i);
      int l;
      l = lat(i);
      return (l == 0) ? in_valid : vs[i][l-1];
   endfunction

   function automatic void adv(int i);
      longint aa, ba, ca, av, bv, cv, pin, pv, zin;
      opnd(i, aa, ba, ca, av, bv, cv);
      pin = bv + cv;
      pv  = rg(i, 3) ? pr[i] : pin;
      zin = av * pv;
      ar[i] = upd(ar[i], sx(a, a_signed), ce_a, rst_a);
      br[i] = upd(br[i], sx(b, b_signed), ce_b, rst_b);
      cr[i] = upd(cr[i], sx(c, c_signed), ce_c, rst_c);
      ap[i] = upd(ap[i], aa, ce_a, rst_a);
      bp[i] = upd(bp[i], ba, ce_b, rst_b);
      cp[i] = upd(cp[i], ca, ce_c, rst_c);
      pr[i] = rst ? 0 : (strobe ? pin : pr[i]);
      zr[i] = rst ? 0 : (strobe ? zin : zr[i]);
      if (rst) vs[i] = '0;
      else if (strobe) vs[i] = {vs[i][1:0], in_valid};
   endfunction

   // compare all instances mid-cycle, then advance model to next edge
   initial begin
      for (int i = 0; i < NC; i++) begin
         ar[i] = 0; ap[i] = 0; br[i] = 0; bp[i] = 0;
         cr[i] = 0; cp[i] = 0; pr[i] = 0; zr[i] = 0; vs[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NC; i++) begin
            chk($sformatf("z cfg%0d", i),
                longint'($signed(zo[i])), zexp(i));
            chk($sformatf("out_valid cfg%0d", i),
                longint'(vo[i]), longint'(vexp(i)));
         end
         for (int i = 0; i < NC; i++) adv(i);
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic randomize_ops();
      a = 18'($urandom());
      b = 18'($urandom());
      c = 18'($urandom());
      a_signed = 1'($urandom());
      b_signed = 1'($urandom());
      c_signed = 1'($urandom());
   endtask

   // literal z check on the default configuration, DUT and model
   task automatic chk_z(string nm, longint want);
      chk({nm, " dut"}, longint'($signed(zo[DUT])), want);
      chk({nm, " model"}, zexp(DUT), want);
   endtask

   task automatic set_ops(logic [17:0] va, logic [17:0] vb,
                          logic [17:0] vc);
      a = va;
      b = vb;
      c = vc;
   endtask

   initial begin
      rst = 1'b1;
      strobe = 1'($urandom());
      in_valid = 1'($urandom());
      ce_a = 1'b1; ce_b = 1'b1; ce_c = 1'b1;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      randomize_ops();
      step(2);
      chk("reset z", longint'(zo[DUT]), 0);
      chk("reset out_valid", longint'(vo[DUT]), 0);

      rst = 1'b0;
      strobe = 1'b0;
      for (int k = 0; k < 3; k++) begin
         randomize_ops();
         in_valid = 1'($urandom());
         step(1);
         chk("hold z", longint'(zo[DUT]), 0);
         chk("hold out_valid", longint'(vo[DUT]), 0);
      end

      strobe = 1'b1;
      in_valid = 1'b0;
      a_signed = 1'b1; b_signed = 1'b1; c_signed = 1'b1;
      set_ops(18'd3, 18'd5, 18'd7);
      step(3);
      chk_z("basic", 36);

      in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      chk("tag +1", longint'(vo[DUT]), 0);
      step(1);
      chk("tag +2", longint'(vo[DUT]), 1);
      step(1);
      chk("tag +3", longint'(vo[DUT]), 0);

      b_signed = 1'b0;
      set_ops(18'h3FFFE, 18'h3FFFF, 18'd0);
      step(3);
      chk_z("mixed sign", -524286);

      b_signed = 1'b1;
      set_ops(18'd3, 18'd5, 18'd7);
      step(3);
      chk_z("pre strobe hold", 36);
      strobe = 1'b0;
      c = 18'd100;
      for (int k = 0; k < 4; k++) begin
         step(1);
         chk_z("strobe hold", 36);
      end
      strobe = 1'b1;
      step(2);
      chk_z("strobe resume", 315);

      set_ops(18'd4, 18'd6, 18'd9);
      step(3);
      chk_z("pre rst_c", 60);
      rst_c = 1'b1;
      step(2);
      chk_z("rst_c", 24);
      rst_c = 1'b0;
      step(3);
      chk_z("resettle", 60);
      strobe = 1'b0;
      rst_c = 1'b1;
      step(3);
      chk_z("rst_c no strobe", 60);
      strobe = 1'b1;
      ce_c = 1'b1;
      step(2);
      chk_z("rst_c over ce_c", 24);
      rst_c = 1'b0;

      for (int k = 0; k < 1500; k++) begin
         rst = ($urandom_range(0, 99) == 0);
         strobe = ($urandom_range(0, 9) != 0);
         ce_a = ($urandom_range(0, 7) != 0);
         ce_b = ($urandom_range(0, 7) != 0);
         ce_c = ($urandom_range(0, 7) != 0);
         rst_a = ($urandom_range(0, 19) == 0);
         rst_b = ($urandom_range(0, 19) == 0);
         rst_c = ($urandom_range(0, 19) == 0);
         in_valid = 1'($urandom());
         randomize_ops();
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mulpreadd_pipe.md
Name: mulpreadd_pipe

Overview:
- Parametrised pre-add multiplier: z = a * (b + c). Each operand's signedness is selectable per operand.
- Every pipeline stage can be registered or bypassed independently, with per-operand clock enable and reset.
- All register updates are qualified by a global strobe.
- It is the generalised successor to the fixed 18x18 single-C-register hardware-test DUTs. It sits between the test sequencer and the result comparator, and carries a valid tag through the pipeline.

Parameters:
- WA, 18, width of a
- WB, 18, width of b
- WC, 18, width of c
- REG_A, 0, 1 = register a and a_signed
- REG_B, 0, 1 = register b and b_signed
- REG_C, 1, 1 = register c and c_signed
- REG_P, 0, 1 = register the pre-adder sum
- REG_Z, 1, 1 = register the output z

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset; clears every register
- strobe  in  1  global advance; no register changes when low (except rst)
- a_signed  in  1  a is two's complement
- b_signed  in  1  b is two's complement
- c_signed  in  1  c is two's complement
- a  in  WA  operand
- b  in  WB  pre-adder operand
- c  in  WC  pre-adder operand
- ce_a  in  1  A register enable
- ce_b  in  1  B register enable
- ce_c  in  1  C register enable
- rst_a  in  1  A register sync clear
- rst_b  in  1  B register sync clear
- rst_c  in  1  C register sync clear
- in_valid  in  1  tag for the current operand set
- out_valid  out  1  tag delayed by LAT
- z  out  ZW  result, two's complement

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Widths:
  - PW = max(WB,WC)+2.
  - ZW = WA+PW+1 (default config: 39).
- Extension: each operand is extended to signed form, sign-extended if its signed flag is 1, zero-extended otherwise.
  - a goes to WA+1 bits; b and c go to PW bits.
  - sum = b_ext + c_ext (PW bits, exact).
  - z = a_ext * sum (ZW bits, exact, never overflows).
- Signed flags travel with their data through the operand register.
- Register update priority, per stage, per clk edge:
  - rst (unconditional) clears the register.
  - Otherwise, if strobe && rst_x, clear.
  - Otherwise, if strobe && ce_x, load.
  - Otherwise hold.
  - P and Z stages use ce = 1 and rst_x = 0, so only rst and strobe affect them.
- Bypassed stage (REG_x = 0): purely combinational. Its ce_x and rst_x are ignored.
- Latency: LAT = max(REG_A,REG_B,REG_C) + REG_P + REG_Z.
  - Operands with fewer registers are NOT delay-matched; mixed-depth operand timing is exactly as the register settings dictate.
- Valid tracker:
  - LAT-deep shift register that advances only when strobe = 1.
  - Cleared by rst only; per-operand resets do not affect it.
  - LAT = 0: out_valid = in_valid combinationally.
- Reset values: z = 0 and out_valid = 0 when REG_Z = 1, and every register is 0.
  - Reset mid-stream drops all in-flight tags. The first out_valid follows LAT strobed cycles after the next in_valid.
- Simultaneous events:
  - rst_x with ce_x: clear wins.
  - strobe = 0 with rst_x: no effect.

Optional Feature:
- Macro: MULTPREADD_ALIGN_EN.
- Defined: each operand path gets extra delay registers so every operand sees max(REG_A,REG_B,REG_C) stages.
  - Padding registers use strobe && ce_x and strobe && rst_x like the primary register.
  - z then equals the aligned product of one operand set, tagged by out_valid.
- Undefined: no padding; behaviour is as above, and out_valid follows the deepest operand path.

Decomposition:
- Package mulpreadd_pkg:
  - functions for PW, ZW and LAT;
  - max helper;
  - operand-extension function.
- Sub-module mulpreadd_stage, instantiated per stage and per padding register:
  - parameters WIDTH and EN;
  - register with rst, strobe, ce, rst_x and bypass.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> z=0 and out_valid=0; stays so while strobe=0 after release.
- Default config, all signed, strobe=1: a=3, b=5, c=7 held for 3 cycles -> z=36. in_valid pulse -> out_valid exactly 2 strobed cycles later.
- Mixed signedness: a=18'h3FFFE signed (-2), b=18'h3FFFF unsigned (262143), c=0, held -> z=-524286.
- Strobe hold:
  - Settle at z=36, then set strobe=0 and change c to 100 for 4 cycles -> z stays 36.
  - Set strobe=1 with ce_c=1 -> z=3*105=315 after 2 cycles.
- Per-operand reset: a=4, b=6, c=9 settled (z=60), rst_c=1 with strobe=1 -> z=24.
  - rst_c=1 with strobe=0 -> no change.
  - rst_c=1 with ce_c=1 -> cleared.
- Sweep REG_* in {0,1}, with and without MULTPREADD_ALIGN_EN, random operands -> z and out_valid match the reference model at LAT.
